// File: rtl/depp_pkg.sv
// DEPP host shared types and defaults.
// FSM states, command bundle, timing constants.
package depp_pkg;

  localparam int SETUP_CYCLES_DEF   = 1;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int CNT_W              = 16;
  localparam int SETUP_W            = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE,
    DONE
  } depp_state_t;

  typedef struct packed {
    logic       addr;
    logic       write;
    logic [7:0] wdata;
  } depp_cmd_t;

endpackage

// File: rtl/depp_sync2.sv
// Two-flop synchronizer for the peripheral wait line.
// Resets to 0 so the host sees an idle peripheral.
module depp_sync2 (
  input  logic i_clk_8mhz,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic meta;

  // shift the asynchronous level through two flops
  always_ff @(posedge i_clk_8mhz) begin
    if (!i_rst_n) begin
      meta   <= 1'b0;
      o_sync <= 1'b0;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/depp_host.sv
// DEPP bus master: one command in, one address/data cycle out.
// Setup, strobe/wait handshake, release, with per-edge timeout.
module depp_host
  import depp_pkg::*;
#(
  parameter int SETUP_CYCLES   = SETUP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       i_clk_8mhz,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_addr,
  input  logic       i_cmd_write,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_timeout,
  output logic       o_depp_astb_n,
  output logic       o_depp_dstb_n,
  output logic       o_depp_write_n,
  input  logic       i_depp_wait,
  inout  wire  [7:0] io_depp_data
);

  localparam logic [SETUP_W-1:0] SETUP_LAST =
    SETUP_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  depp_state_t state;
  depp_state_t state_nx;
  depp_cmd_t   cmd;

  logic [SETUP_W-1:0] setup_cnt;
  logic [CNT_W-1:0]   wait_cnt;

  logic wait_s;
  logic accept;
  logic setup_last;
  logic wait_last;
  logic abort;
  logic bus_phase;
  logic drive;
  logic tmo;

  depp_sync2 u_sync (
    .i_clk_8mhz (i_clk_8mhz),
    .i_rst_n    (i_rst_n),
    .i_async    (i_depp_wait),
    .o_sync     (wait_s)
  );

  assign accept     = i_cmd_valid & (state == IDLE);
  assign setup_last = (setup_cnt == SETUP_LAST);
  assign wait_last  = (wait_cnt == WAIT_LAST);

  assign io_depp_data = drive ? cmd.wdata : 8'hzz;

  // next state, bus controls and response qualifiers
  always_comb begin
    state_nx       = state;
    abort          = 1'b0;
    bus_phase      = 1'b0;
    o_cmd_ready    = 1'b0;
    o_rsp_valid    = 1'b0;
    o_rsp_timeout  = 1'b0;
    o_depp_astb_n  = 1'b1;
    o_depp_dstb_n  = 1'b1;
    unique case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) state_nx = SETUP;
      end
      SETUP: begin
        bus_phase = 1'b1;
        if (setup_last) state_nx = STROBE;
      end
      STROBE: begin
        bus_phase     = 1'b1;
        o_depp_astb_n = ~cmd.addr;
        o_depp_dstb_n = cmd.addr;
        if (wait_s) begin
          state_nx = RELEASE;
        end else if (wait_last) begin
          state_nx = DONE;
          abort    = 1'b1;
        end
      end
      RELEASE: begin
        bus_phase = 1'b1;
        if (!wait_s) begin
          state_nx = DONE;
        end else if (wait_last) begin
          state_nx = DONE;
          abort    = 1'b1;
        end
      end
      DONE: begin
        o_rsp_valid   = 1'b1;
        o_rsp_timeout = tmo;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign drive          = bus_phase & cmd.write;
  assign o_depp_write_n = ~drive;

  // state register
  always_ff @(posedge i_clk_8mhz) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // latch the command fields on accept only
  always_ff @(posedge i_clk_8mhz) begin
    if (!i_rst_n) begin
      cmd <= '0;
    end else if (accept) begin
      cmd.addr  <= i_cmd_addr;
      cmd.write <= i_cmd_write;
      cmd.wdata <= i_cmd_wdata;
    end
  end

  // setup length counter, idle at zero outside SETUP
  always_ff @(posedge i_clk_8mhz) begin
    if (!i_rst_n)              setup_cnt <= '0;
    else if (state == SETUP)   setup_cnt <= setup_cnt + 1'b1;
    else                       setup_cnt <= '0;
  end

  // wait-edge counter, restarted on every state change
  always_ff @(posedge i_clk_8mhz) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
    end else if (state_nx != state) begin
      wait_cnt <= '0;
    end else if (state == STROBE || state == RELEASE) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // read capture on the handshake edge, abort flag on DONE entry
  always_ff @(posedge i_clk_8mhz) begin
    if (!i_rst_n) begin
      o_rsp_rdata <= 8'h00;
      tmo         <= 1'b0;
    end else begin
      if (state == STROBE && wait_s && !cmd.write)
        o_rsp_rdata <= io_depp_data;
      if (state_nx == DONE && state != DONE)
        tmo <= abort;
    end
  end

endmodule

// File: tb/tb_depp_host.sv
// Bench for depp_host against a behavioural DEPP peripheral.
// Reference model tracks peripheral registers and expected responses.
module tb_depp_host;

  localparam int SETUP = 2;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_addr = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       astb_n;
  logic       dstb_n;
  logic       write_n;
  logic       depp_wait;
  wire  [7:0] bus;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  depp_host #(
    .SETUP_CYCLES   (SETUP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk_8mhz     (clk),
    .i_rst_n        (rst_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_write    (cmd_write),
    .i_cmd_wdata    (cmd_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_timeout  (rsp_timeout),
    .o_depp_astb_n  (astb_n),
    .o_depp_dstb_n  (dstb_n),
    .o_depp_write_n (write_n),
    .i_depp_wait    (depp_wait),
    .io_depp_data   (bus)
  );

  // peripheral: address register plus 256-byte data store
  logic       wait_r = 1'b0;
  int         lo_cnt = 0;
  int         hi_cnt = 0;
  int         rise_dly = 3;
  int         drop_dly = 2;
  bit         never = 1'b0;
  logic [7:0] p_addr = 8'h00;
  logic [7:0] p_mem [256] = '{default: 8'h00};
  logic       p_oe;
  logic [7:0] p_drv;

  assign p_oe      = (!astb_n || !dstb_n) && write_n;
  assign p_drv     = !astb_n ? p_addr : p_mem[p_addr];
  assign bus       = p_oe ? p_drv : 8'hzz;
  assign depp_wait = wait_r;

  always @(posedge clk) begin
    if (!astb_n || !dstb_n) begin
      hi_cnt <= 0;
      lo_cnt <= lo_cnt + 1;
      if (lo_cnt == rise_dly && !never) begin
        wait_r <= 1'b1;
        if (!write_n) begin
          if (!astb_n) p_addr <= bus;
          else         p_mem[p_addr] <= bus;
        end
      end
    end else begin
      lo_cnt <= 0;
      if (wait_r) begin
        if (hi_cnt == drop_dly) wait_r <= 1'b0;
        hi_cnt <= hi_cnt + 1;
      end else begin
        hi_cnt <= 0;
      end
    end
  end

  // reference model state
  logic [7:0] r_addr = 8'h00;
  logic [7:0] r_mem [256] = '{default: 8'h00};
  logic [7:0] last_rdata = 8'h00;
  int         exp_rsp = 0;

  // protocol monitor
  int   ncyc = 0;
  int   acc_mark = 0;
  int   setup_len = 0;
  int   lo_len = 0;
  bit   prev_stb = 1'b0;
  int   rsp_cnt = 0;
  int   v_overlap = 0;
  int   v_wrong = 0;
  int   v_ctl = 0;
  int   v_bus = 0;
  logic cur_a = 1'b0;
  logic cur_w = 1'b0;
  logic [7:0] cur_wd = 8'h00;

  always @(posedge clk) begin
    if (rst_n && cmd_ready && cmd_valid) begin
      acc_mark = ncyc;
      cur_a    = cmd_addr;
      cur_w    = cmd_write;
      cur_wd   = cmd_wdata;
    end
  end

  always @(negedge clk) begin
    bit stb;
    ncyc++;
    stb = !astb_n || !dstb_n;
    if (!astb_n && !dstb_n) v_overlap++;
    if (stb && (cur_a ? !dstb_n : !astb_n)) v_wrong++;
    if ((stb || !write_n) && cmd_ready) v_ctl++;
    if (!write_n && (!cur_w || bus !== cur_wd)) v_bus++;
    if (write_n && !stb && !(bus === 8'hff || bus === 8'hzz)) v_bus++;
    if (write_n && stb && bus !== p_drv) v_bus++;
    if (stb) begin
      if (!prev_stb) begin
        setup_len = ncyc - acc_mark - 1;
        lo_len    = 1;
      end else begin
        lo_len++;
      end
    end
    prev_stb = stb;
    if (rsp_valid) rsp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_cmd(input bit a, input bit w, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", cmd_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_cmd(input bit a, input bit w,
                            input logic [7:0] d, input bit nv);
    int n = 0;
    if (!nv) begin
      if (w) begin
        if (a) r_addr = d;
        else   r_mem[r_addr] = d;
      end else begin
        last_rdata = a ? r_addr : r_mem[r_addr];
      end
    end
    exp_rsp++;
    @(negedge clk);
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", rsp_valid, 1);
    check("rsp_tmo", rsp_timeout, nv);
    check("rsp_rdata", rsp_rdata, last_rdata);
    check("busy_done", cmd_ready, 0);
    check("setup_len", setup_len, SETUP);
    if (nv) check("stb_len", lo_len, TMO);
    @(negedge clk);
    check("idle_after", cmd_ready, 1);
  endtask

  task automatic run_cmd(input bit a, input bit w,
                         input logic [7:0] d, input bit nv);
    never = nv;
    start_cmd(a, w, d);
    cmd_valid = 1'b0;
    finish_cmd(a, w, d, nv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    bit a, w, nv;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    check("rst_astb", astb_n, 1);
    check("rst_dstb", dstb_n, 1);
    check("rst_wrn", write_n, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_tmo", rsp_timeout, 0);
    check("rst_rdata", rsp_rdata, 8'h00);
    check("rst_bus", (bus === 8'hff) || (bus === 8'hzz), 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);

    rise_dly = 3;
    drop_dly = 2;
    run_cmd(1'b1, 1'b1, 8'hA5, 1'b0);
    run_cmd(1'b0, 1'b1, 8'h3C, 1'b0);
    run_cmd(1'b0, 1'b0, 8'h00, 1'b0);
    check("rd_3c", rsp_rdata, 8'h3C);

    run_cmd(1'b0, 1'b0, 8'h00, 1'b1);
    check("tmo_keep", rsp_rdata, 8'h3C);

    never = 1'b0;
    start_cmd(1'b1, 1'b1, 8'h07);
    cmd_addr  = 1'b1;
    cmd_write = 1'b0;
    cmd_wdata = 8'hEE;
    finish_cmd(1'b1, 1'b1, 8'h07, 1'b0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("b2b_acc", cmd_ready, 0);
    finish_cmd(1'b1, 1'b0, 8'hEE, 1'b0);
    check("rd_07", rsp_rdata, 8'h07);

    never = 1'b1;
    start_cmd(1'b0, 1'b0, 8'h00);
    cmd_valid = 1'b0;
    n = 0;
    while (astb_n && dstb_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_stb_low", dstb_n, 0);
    base = rsp_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_stb", {astb_n, dstb_n}, 2'b11);
    check("rst_mid_wrn", write_n, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_mid_rdy", cmd_ready, 1);
    check("rst_no_rsp", rsp_cnt, base);

    for (int i = 0; i < 40; i++) begin
      a  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      nv = ($urandom_range(0, 9) == 0);
      rise_dly = $urandom_range(0, 3);
      drop_dly = $urandom_range(0, 3);
      run_cmd(a, w, d, nv);
    end

    repeat (3) @(negedge clk);
    check("overlap", v_overlap, 0);
    check("wrong_stb", v_wrong, 0);
    check("ctl_idle", v_ctl, 0);
    check("bus_drive", v_bus, 0);
    check("rsp_count", rsp_cnt, exp_rsp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
